dm_responder: RTL

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder_pkg.sv | 39 +++
 rtl/dm_trace_fifo.sv | 61 ++++++
 rtl/dm_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: constants and types shared by the data-memory responder
// and the CPU byte-enable logic.
//   DM_TRACE_W         - width of one packed write-trace record (pc, addr, data)
//   DM_DEPTH_WORDS_DEF - default data memory size in 32-bit words
//   BE_*               - byte-lane enable encodings (bit i -> bits [8i+7:8i])
//   trace_rec_t        - packed trace record
//   be_merge()         - merge enabled byte lanes of new data into an old word
package dm_responder_pkg;

    localparam int DM_TRACE_W         = 96;
    localparam int DM_DEPTH_WORDS_DEF = 3072;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_H0   = 4'b0011;
    localparam logic [3:0] BE_H1   = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_trace_fifo.sv
// dm_trace_fifo: synchronous FIFO for write-trace records.
//   clk, reset - clock, asynchronous active-high reset (empties the FIFO)
//   push, din  - write request and data; ignored when full unless popping
//   pop        - read request; ignored when empty
//   dout       - head entry, 0 while empty
//   empty/full - status
// DEPTH must be a power of two (>= 2). Pointers carry one extra wrap bit so
// equal indices can be told apart as empty (same wrap) or full (opposite).
module dm_trace_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wp_q, wp_d;
    logic [PW:0]      rp_q, rp_d;
    logic             do_push, do_pop;

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);

    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = empty ? '0 : mem_q[rp_q[PW-1:0]];

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (do_push) wp_d = wp_q + 1'b1;
        if (do_pop)  rp_d = rp_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: zero-wait-state data memory for the CPU M stage with an
// out-of-range write counter and an optional write-trace stream.
//   clk, reset      - clock, asynchronous active-high reset (clears memory)
//   m_data_addr     - byte address; word index = addr[31:2]
//   m_data_wdata    - lane-aligned write data
//   m_data_byteen   - byte-lane write enables (0 = no write)
//   m_inst_addr     - PC of the writing instruction (trace only)
//   m_data_rdata    - combinational read word, 0 when out of range
//   oor_count       - saturating count of out-of-range writes
//   trace_*         - valid/ready stream of {pc, word addr, merged word}
// Build option: define DM_TRACE_EN to include the trace FIFO; otherwise the
// trace outputs are tied to 0 and trace_ready is ignored.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS_DEF,
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic [15:0] oor_count,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [29:0]   widx;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          wr_any, wr_en, oor_wr;
    logic [31:0]   cur_word, merged;
    logic [15:0]   oor_q, oor_d;

    assign widx     = m_data_addr[31:2];
    assign idx      = widx[AW-1:0];
    assign in_range = ({2'b00, widx} < 32'(DEPTH_WORDS));
    assign wr_any   = (m_data_byteen != BE_NONE);
    assign wr_en    = wr_any && in_range;
    assign oor_wr   = wr_any && !in_range;

    // Read returns the pre-write word; the write lands on the clock edge.
    assign cur_word     = in_range ? mem_q[idx] : 32'h0;
    assign m_data_rdata = cur_word;
    assign merged       = be_merge(cur_word, m_data_wdata, m_data_byteen);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx] <= merged;
        end
    end

    always_comb begin
        oor_d = oor_q;
        if (oor_wr && oor_q != 16'hFFFF) oor_d = oor_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) oor_q <= '0;
        else       oor_q <= oor_d;
    end

    assign oor_count = oor_q;

`ifdef DM_TRACE_EN
    trace_rec_t rec_in, rec_out;
    logic       f_empty, f_full, f_pop;
    logic       ovf_q, ovf_d;

    assign rec_in = '{pc: m_inst_addr, addr: {widx, 2'b00}, data: merged};
    assign f_pop  = !f_empty && trace_ready;

    dm_trace_fifo #(
        .WIDTH (DM_TRACE_W),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .din   (rec_in),
        .pop   (f_pop),
        .dout  (rec_out),
        .empty (f_empty),
        .full  (f_full)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && f_full && !f_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign trace_valid    = !f_empty;
    assign trace_pc       = rec_out.pc;
    assign trace_addr     = rec_out.addr;
    assign trace_data     = rec_out.data;
    assign trace_overflow = ovf_q;

    logic unused_bits;
    assign unused_bits = ^m_data_addr[1:0];
`else
    assign trace_valid    = 1'b0;
    assign trace_pc       = '0;
    assign trace_addr     = '0;
    assign trace_data     = '0;
    assign trace_overflow = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{m_data_addr[1:0], m_inst_addr, trace_ready};
`endif

endmodule
